// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: definitions shared between the CPU data path and the
// data-memory arbiter.
//   DMEM_AW_DEF  : default data-memory word-address width
//   MEM_TYPE_*   : access-size codes carried on the *_type fields; they are
//                  interpreted only by Data_Memory
//   arb_state_e  : arbiter FSM state encoding
package dmem_arbiter_pkg;

    localparam int DMEM_AW_DEF = 11;

    localparam logic [1:0] MEM_TYPE_B  = 2'd0;
    localparam logic [1:0] MEM_TYPE_H  = 2'd1;
    localparam logic [1:0] MEM_TYPE_W  = 2'd2;
    localparam logic [1:0] MEM_TYPE_BU = 2'd3;

    typedef enum logic {
        CPU_PRI   = 1'b0,
        DBG_FORCE = 1'b1
    } arb_state_e;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single Data_Memory port between the CPU MEM stage
// and a loader/debug port. The CPU normally has priority; a debug request that
// has waited STARVE_MAX consecutive cycles is forced through for one grant.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   cpu_req/we/type/addr/wdata_i  CPU access request (MEM stage)
//   cpu_stall_o            CPU request not served this cycle
//   cpu_rdata_o            load data in the served cycle (0-cycle latency)
//   dbg_req/we/type/addr/wdata_i  debug request, held until granted
//   dbg_gnt_o              debug request accepted this cycle
//   dbg_rvalid_o/rdata_o   registered debug read response
//   mem_*                  shared Data_Memory port (sync write, comb read)
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int DMEM_AW    = DMEM_AW_DEF,
    parameter int STARVE_MAX = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,

    input  logic               cpu_req_i,
    input  logic               cpu_we_i,
    input  logic [1:0]         cpu_type_i,
    input  logic [DMEM_AW-1:0] cpu_addr_i,
    input  logic [31:0]        cpu_wdata_i,
    output logic               cpu_stall_o,
    output logic [31:0]        cpu_rdata_o,

    input  logic               dbg_req_i,
    input  logic               dbg_we_i,
    input  logic [1:0]         dbg_type_i,
    input  logic [DMEM_AW-1:0] dbg_addr_i,
    input  logic [31:0]        dbg_wdata_i,
    output logic               dbg_gnt_o,
    output logic               dbg_rvalid_o,
    output logic [31:0]        dbg_rdata_o,

    output logic               mem_ena_o,
    output logic               mem_wena_o,
    output logic [1:0]         mem_type_o,
    output logic [DMEM_AW-1:0] mem_addr_o,
    output logic [31:0]        mem_wdata_o,
    input  logic [31:0]        mem_rdata_i
);

    localparam int CNT_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    arb_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dbg_rvalid_q, dbg_rvalid_d;
    logic [31:0]       dbg_rdata_q, dbg_rdata_d;
    logic              cpu_gnt, dbg_gnt;
    logic              dbg_waiting;

    // Grant selection; nothing is granted while reset is asserted.
    always_comb begin
        cpu_gnt = 1'b0;
        dbg_gnt = 1'b0;
        if (!rst_i) begin
            if (state_q == CPU_PRI) begin
                cpu_gnt = cpu_req_i;
                dbg_gnt = dbg_req_i && !cpu_req_i;
            end else begin
                dbg_gnt = dbg_req_i;
                cpu_gnt = cpu_req_i && !dbg_req_i;
            end
        end
    end

    assign dbg_waiting = dbg_req_i && !dbg_gnt;

    // Starvation counter, FSM next state and debug read-response capture.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        dbg_rvalid_d = dbg_gnt && !dbg_we_i;
        dbg_rdata_d  = dbg_rdata_q;

        if (dbg_waiting) begin
            cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
        end

        case (state_q)
            CPU_PRI: begin
                // Qualified by dbg_waiting so STARVE_MAX=0 does not force
                // a state change while debug is idle.
                if (dbg_waiting && (cnt_d == CNT_MAX)) begin
                    state_d = DBG_FORCE;
                end
            end
            DBG_FORCE: begin
                if (dbg_gnt || !dbg_req_i) begin
                    state_d = CPU_PRI;
                end
            end
            default: state_d = CPU_PRI;
        endcase

        if (dbg_rvalid_d) begin
            dbg_rdata_d = mem_rdata_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= CPU_PRI;
            cnt_q        <= '0;
            dbg_rvalid_q <= 1'b0;
            dbg_rdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            dbg_rvalid_q <= dbg_rvalid_d;
            dbg_rdata_q  <= dbg_rdata_d;
        end
    end

    // Memory port mux: driven by the granted requester, all-zero when idle.
    always_comb begin
        mem_ena_o   = 1'b0;
        mem_wena_o  = 1'b0;
        mem_type_o  = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (cpu_gnt) begin
            mem_ena_o   = 1'b1;
            mem_wena_o  = cpu_we_i;
            mem_type_o  = cpu_type_i;
            mem_addr_o  = cpu_addr_i;
            mem_wdata_o = cpu_wdata_i;
        end else if (dbg_gnt) begin
            mem_ena_o   = 1'b1;
            mem_wena_o  = dbg_we_i;
            mem_type_o  = dbg_type_i;
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
        end
    end

    assign cpu_stall_o  = cpu_req_i && !cpu_gnt && !rst_i;
    assign cpu_rdata_o  = (cpu_gnt && !cpu_we_i) ? mem_rdata_i : 32'd0;
    assign dbg_gnt_o    = dbg_gnt;
    // A response pulse pending when reset arrives is suppressed immediately.
    assign dbg_rvalid_o = dbg_rvalid_q && !rst_i;
    assign dbg_rdata_o  = dbg_rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;
    import dmem_arbiter_pkg::*;

    localparam int AW = 11;
    localparam int SM = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_req, cpu_we;
    logic [1:0]    cpu_type;
    logic [AW-1:0] cpu_addr;
    logic [31:0]   cpu_wdata;
    logic          cpu_stall;
    logic [31:0]   cpu_rdata;
    logic          dbg_req, dbg_we;
    logic [1:0]    dbg_type;
    logic [AW-1:0] dbg_addr;
    logic [31:0]   dbg_wdata;
    logic          dbg_gnt, dbg_rvalid;
    logic [31:0]   dbg_rdata;
    logic          mem_ena, mem_wena;
    logic [1:0]    mem_type;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata, mem_rdata;

    int n_chk  = 0;
    int n_fail = 0;

    // Behavioural Data_Memory: synchronous write, combinational read.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_ena && mem_wena) mem[mem_addr] <= mem_wdata;
    end
    assign mem_rdata = mem[mem_addr];

    always #5 clk = ~clk;

    dmem_arbiter #(.DMEM_AW(AW), .STARVE_MAX(SM)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_type_i(cpu_type),
        .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
        .cpu_stall_o(cpu_stall), .cpu_rdata_o(cpu_rdata),
        .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_type_i(dbg_type),
        .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
        .dbg_gnt_o(dbg_gnt), .dbg_rvalid_o(dbg_rvalid), .dbg_rdata_o(dbg_rdata),
        .mem_ena_o(mem_ena), .mem_wena_o(mem_wena), .mem_type_o(mem_type),
        .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic set_cpu(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
        cpu_req = req; cpu_we = we; cpu_type = MEM_TYPE_W; cpu_addr = a; cpu_wdata = d;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [AW-1:0] a, input logic [31:0] d);
        dbg_req = req; dbg_we = we; dbg_type = MEM_TYPE_W; dbg_addr = a; dbg_wdata = d;
    endtask

    // Reference model state for the randomized phase.
    logic [31:0] shadow [0:(1<<AW)-1];
    int          waited;
    logic        exp_rvalid;
    logic [31:0] exp_rdata;

    initial begin
        logic          c_srv, d_srv;
        logic          c_we;
        logic [1:0]    c_ty;
        logic [AW-1:0] c_a;
        logic [31:0]   c_d;

        // ---------------- reset with both requesters writing
        rst = 1'b1;
        set_cpu(1'b1, 1'b1, 11'h040, 32'h11111111);
        set_dbg(1'b1, 1'b1, 11'h041, 32'h22222222);
        #1; settle();
        chk1("rst_mem_ena", mem_ena, 1'b0);
        chk1("rst_mem_wena", mem_wena, 1'b0);
        chk1("rst_dbg_gnt", dbg_gnt, 1'b0);
        chk1("rst_cpu_stall", cpu_stall, 1'b0);
        tick();
        settle();
        chk1("rst_mem_wena2", mem_wena, 1'b0);
        chk1("rst_rvalid", dbg_rvalid, 1'b0);
        chk("rst_rdata", dbg_rdata, 32'h0);
        chk("rst_state", 32'(dut.state_q), 32'(CPU_PRI));
        chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dbg(1'b0, 1'b0, '0, '0);
        tick();
        rst = 1'b0;

        // ---------------- CPU write then read, debug idle
        set_cpu(1'b1, 1'b1, 11'h010, 32'hDEADBEEF);
        settle();
        chk1("cpuwr_stall", cpu_stall, 1'b0);
        chk1("cpuwr_wena", mem_wena, 1'b1);
        chk("cpuwr_addr", 32'(mem_addr), 32'h010);
        tick();
        set_cpu(1'b1, 1'b0, 11'h010, 32'h0);
        settle();
        chk1("cpurd_stall", cpu_stall, 1'b0);
        chk("cpurd_data", cpu_rdata, 32'hDEADBEEF);
        tick();

        // ---------------- debug read, CPU idle
        set_cpu(1'b1, 1'b1, 11'h020, 32'h12345678);
        tick();
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dbg(1'b1, 1'b0, 11'h020, 32'h0);
        settle();
        chk1("dbgrd_gnt", dbg_gnt, 1'b1);
        chk1("dbgrd_rvalid_early", dbg_rvalid, 1'b0);
        tick();
        set_dbg(1'b0, 1'b0, '0, '0);
        settle();
        chk1("dbgrd_rvalid", dbg_rvalid, 1'b1);
        chk("dbgrd_rdata", dbg_rdata, 32'h12345678);
        tick();
        settle();
        chk1("dbgrd_rvalid_pulse", dbg_rvalid, 1'b0);
        chk("dbgrd_rdata_hold", dbg_rdata, 32'h12345678);

        // ---------------- starvation: CPU continuous, debug from cycle 0
        set_cpu(1'b1, 1'b0, 11'h010, 32'h0);
        set_dbg(1'b1, 1'b1, 11'h050, 32'hCAFEF00D);
        for (int c = 0; c < 8; c++) begin
            settle();
            chk1($sformatf("starve_stall_c%0d", c), cpu_stall, c == 4);
            chk1($sformatf("starve_gnt_c%0d", c), dbg_gnt, c == 4);
            chk($sformatf("starve_rdata_c%0d", c), cpu_rdata, (c == 4) ? 32'h0 : 32'hDEADBEEF);
            chk($sformatf("starve_cnt_c%0d", c), 32'(dut.cnt_q), (c <= 4) ? c : 0);
            tick();
            if (c == 4) set_dbg(1'b0, 1'b0, '0, '0);
        end
        chk("starve_dbg_write", mem[11'h050], 32'hCAFEF00D);

        // ---------------- simultaneous writes to 0x030
        set_cpu(1'b1, 1'b1, 11'h030, 32'hAAAA0001);
        set_dbg(1'b1, 1'b1, 11'h030, 32'hBBBB0002);
        settle();
        chk1("both_dbg_gnt0", dbg_gnt, 1'b0);
        chk("both_wdata0", mem_wdata, 32'hAAAA0001);
        tick();
        chk("both_cpu_landed", mem[11'h030], 32'hAAAA0001);
        set_cpu(1'b0, 1'b0, '0, '0);
        settle();
        chk1("both_dbg_gnt1", dbg_gnt, 1'b1);
        chk("both_wdata1", mem_wdata, 32'hBBBB0002);
        tick();
        set_dbg(1'b0, 1'b0, '0, '0);
        set_cpu(1'b1, 1'b0, 11'h030, 32'h0);
        settle();
        chk("both_readback", cpu_rdata, 32'hBBBB0002);
        tick();

        // ---------------- reset in the cycle after a debug read grant
        set_cpu(1'b0, 1'b0, '0, '0);
        set_dbg(1'b1, 1'b0, 11'h010, 32'h0);
        settle();
        chk1("rstmid_gnt", dbg_gnt, 1'b1);
        tick();
        rst = 1'b1;
        set_dbg(1'b0, 1'b0, '0, '0);
        set_cpu(1'b1, 1'b1, 11'h060, 32'h5A5A5A5A);
        settle();
        chk1("rstmid_rvalid", dbg_rvalid, 1'b0);
        chk1("rstmid_wena", mem_wena, 1'b0);
        tick();
        rst = 1'b0;
        set_cpu(1'b0, 1'b0, '0, '0);
        settle();
        chk("rstmid_state", 32'(dut.state_q), 32'(CPU_PRI));
        chk1("rstmid_rvalid2", dbg_rvalid, 1'b0);
        chk("rstmid_rdata", dbg_rdata, 32'h0);
        tick();

        // ---------------- debug drops at counter=3
        set_cpu(1'b1, 1'b0, 11'h010, 32'h0);
        set_dbg(1'b1, 1'b0, 11'h020, 32'h0);
        tick(); tick(); tick();
        set_dbg(1'b0, 1'b0, '0, '0);
        settle();
        chk("drop_cnt3", 32'(dut.cnt_q), 32'd3);
        chk1("drop_gnt", dbg_gnt, 1'b0);
        tick();
        for (int c = 0; c < 5; c++) begin
            settle();
            chk($sformatf("drop_cnt_c%0d", c), 32'(dut.cnt_q), 32'd0);
            chk($sformatf("drop_state_c%0d", c), 32'(dut.state_q), 32'(CPU_PRI));
            chk1($sformatf("drop_stall_c%0d", c), cpu_stall, 1'b0);
            chk1($sformatf("drop_gnt_c%0d", c), dbg_gnt, 1'b0);
            tick();
        end

        // ---------------- randomized traffic against the reference model
        set_cpu(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 16; i++) begin
            shadow[11'h100 + i] = $urandom;
            set_cpu(1'b1, 1'b1, 11'(11'h100 + i), shadow[11'h100 + i]);
            tick();
        end
        set_cpu(1'b0, 1'b0, '0, '0);
        tick();
        waited     = 0;
        exp_rvalid = 1'b0;
        exp_rdata  = 32'h0;   // last debug read response was cleared by reset
        for (int cyc = 0; cyc < 3000; cyc++) begin
            // Debug request is held until granted; new one appears randomly.
            if (!dbg_req && ($urandom_range(2) == 0)) begin
                dbg_req   = 1'b1;
                dbg_we    = $urandom_range(1);
                dbg_type  = 2'($urandom_range(3));
                dbg_addr  = 11'(11'h100 + $urandom_range(15));
                dbg_wdata = $urandom;
            end
            c_we = $urandom_range(1);
            c_ty = 2'($urandom_range(3));
            c_a  = 11'(11'h100 + $urandom_range(15));
            c_d  = $urandom;
            cpu_req = ($urandom_range(3) != 0);
            cpu_we = c_we; cpu_type = c_ty; cpu_addr = c_a; cpu_wdata = c_d;
            settle();

            // Debug wins if the CPU is idle or debug has waited STARVE_MAX cycles.
            d_srv = dbg_req && (!cpu_req || waited >= SM);
            c_srv = cpu_req && !d_srv;

            chk1("rnd_stall", cpu_stall, cpu_req && !c_srv);
            chk1("rnd_gnt", dbg_gnt, d_srv);
            chk1("rnd_ena", mem_ena, c_srv || d_srv);
            chk1("rnd_wena", mem_wena, c_srv ? c_we : (d_srv ? dbg_we : 1'b0));
            chk("rnd_addr", 32'(mem_addr), c_srv ? 32'(c_a) : (d_srv ? 32'(dbg_addr) : 32'h0));
            chk("rnd_type", 32'(mem_type), c_srv ? 32'(c_ty) : (d_srv ? 32'(dbg_type) : 32'h0));
            chk("rnd_cpu_rdata", cpu_rdata, (c_srv && !c_we) ? shadow[c_a] : 32'h0);
            chk1("rnd_rvalid", dbg_rvalid, exp_rvalid);
            chk("rnd_dbg_rdata", dbg_rdata, exp_rdata);

            exp_rvalid = d_srv && !dbg_we;
            if (exp_rvalid) exp_rdata = shadow[dbg_addr];
            if (c_srv && c_we) shadow[c_a] = c_d;
            if (d_srv && dbg_we) shadow[dbg_addr] = dbg_wdata;
            if (dbg_req && !d_srv) waited = (waited < SM) ? waited + 1 : SM;
            else waited = 0;

            tick();
            if (d_srv) dbg_req = 1'b0;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The block SHALL have parameter DMEM_AW, default 11, data-memory word-address width.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, the maximum number of consecutive cycles the debug port waits while the CPU holds the port.
REQ-003 The block SHALL have port clk_i  in  1  single clock; all state on rising edge.
REQ-004 The block SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have CPU ports cpu_req_i in 1, cpu_we_i in 1, cpu_type_i in 2, cpu_addr_i in DMEM_AW, cpu_wdata_i in 32: the MEM-stage access request.
REQ-006 The block SHALL have CPU ports cpu_stall_o out 1 (CPU access not served this cycle) and cpu_rdata_o out 32 (load data, valid in the served cycle).
REQ-007 The block SHALL have debug ports dbg_req_i in 1, dbg_we_i in 1, dbg_type_i in 2, dbg_addr_i in DMEM_AW, dbg_wdata_i in 32: loader/debug request, held until granted.
REQ-008 The block SHALL have debug ports dbg_gnt_o out 1 (request accepted this cycle), dbg_rvalid_o out 1 and dbg_rdata_o out 32 (registered read response).
REQ-009 The block SHALL have memory ports mem_ena_o out 1, mem_wena_o out 1, mem_type_o out 2, mem_addr_o out DMEM_AW, mem_wdata_o out 32 and mem_rdata_i in 32: the single shared Data_Memory port (synchronous write, combinational read).

Function
REQ-010 The block SHALL serve at most one requester per cycle; mem_* is driven from the granted requester, else mem_ena_o=0, mem_wena_o=0 and the other mem_* outputs are 0.
REQ-011 The block SHALL implement FSM states CPU_PRI and DBG_FORCE.
REQ-012 In CPU_PRI, the block SHALL grant the CPU if cpu_req_i=1, else grant debug if dbg_req_i=1.
REQ-013 In DBG_FORCE, the block SHALL grant debug if dbg_req_i=1, else grant the CPU if cpu_req_i=1.
REQ-014 The block SHALL hold a wait counter (width ceil(log2(STARVE_MAX+1))) that increments each cycle dbg_req_i=1 and debug is not granted, saturating at STARVE_MAX, and clears when debug is granted or dbg_req_i=0.
REQ-015 The block SHALL move CPU_PRI->DBG_FORCE on the edge where the counter's next value equals STARVE_MAX; DBG_FORCE->CPU_PRI after the cycle in which debug is granted or dbg_req_i=0.
REQ-016 The block SHALL drive cpu_stall_o=1 exactly when cpu_req_i=1 and the CPU is not granted; it is combinational, with no cycle of latency.
REQ-017 The block SHALL drive cpu_rdata_o=mem_rdata_i when the CPU is granted with cpu_we_i=0, else 0; CPU load latency is 0 cycles.
REQ-018 The block SHALL drive dbg_gnt_o=1, combinationally, in every cycle debug is granted.
REQ-019 On a debug read grant, the block SHALL register mem_rdata_i into dbg_rdata_o and pulse dbg_rvalid_o=1 for exactly the next cycle; on a debug write grant, dbg_rvalid_o SHALL stay 0.
REQ-020 The block SHALL hold dbg_rdata_o until the next debug read response.
REQ-021 The block SHALL pass the type field unchanged; address and data are not modified (byte/half handling stays in Data_Memory).
REQ-022 When both requesters are idle, the block SHALL hold its state and the counter SHALL be 0.

Reset
REQ-023 While rst_i=1 at a rising edge, the block SHALL set state=CPU_PRI, wait counter=0, dbg_rvalid_o=0 and dbg_rdata_o=0.
REQ-024 While rst_i=1, the block SHALL hold mem_ena_o=0, mem_wena_o=0, dbg_gnt_o=0 and cpu_stall_o=0, and grant nothing.
REQ-025 Reset asserted mid-operation SHALL drop any pending dbg_rvalid_o pulse; no write SHALL reach memory in a reset cycle.

Structure
REQ-026 The block SHALL take the FSM state encoding, DMEM_AW and the memory type codes from the shared CPU package; STARVE_MAX stays local.
REQ-027 The block SHALL be one module with no sub-modules; Data_Memory stays instantiated outside and connects through the mem_* ports.

Verification
REQ-028 Bench: CPU write then read of addr 0x010, data 0xDEADBEEF, debug idle -> cpu_stall_o=0 both cycles, and cpu_rdata_o=0xDEADBEEF in the read cycle.
REQ-029 Bench: debug read of addr 0x020, CPU idle -> dbg_gnt_o=1 in the same cycle, dbg_rvalid_o=1 the next cycle, dbg_rdata_o equal to the memory contents.
REQ-030 Bench: cpu_req_i=1 continuously, dbg_req_i=1 from cycle 0, STARVE_MAX=4 -> debug granted in cycle 4, cpu_stall_o=1 only in cycle 4, CPU served cycles 0-3 and 5+.
REQ-031 Bench: CPU and debug both write addr 0x030 in the same cycle (CPU_PRI) -> CPU data written, debug write lands on its later grant, and a final readback returns the debug data.
REQ-032 Bench: rst_i asserted in the cycle after a debug read grant -> dbg_rvalid_o=0, state=CPU_PRI, no mem_wena_o pulse.
REQ-033 Bench: dbg_req_i drops at counter=3 -> counter returns to 0, state stays CPU_PRI, no forced grant.
